s386_resp_capture: RTL and testbench

// - Downstream stage of the s386 sequential benchmark core. Samples its 7-bit primary

---
 rtl/s386_resp_capture.sv | 120 ++++++++++++
 tb/tb_s386_resp_capture.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/s386_resp_capture.sv
`default_nettype none
// ============================================================================
// Module      : s386_resp_capture
// Description : Response capture stage for the s386 benchmark core. Samples
//               the 7-bit primary output vector on strobe into a FIFO for a
//               ready/valid consumer, compacts every sample into a MISR
//               signature, counts samples (saturating) and flags drops.
// Revision    : 1.0 - initial release
// ============================================================================
module s386_resp_capture #(
  parameter int          DEPTH = 8,
  parameter int          SIG_W = 16,
  parameter logic [31:0] POLY  = 32'h0000_100B
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             clr,
  input  logic             en,
  input  logic [6:0]       din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_data,
  output logic             full,
  output logic             empty,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      cnt,
  output logic             ovf
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   C_PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [SIG_W-1:0] C_POLY = POLY[SIG_W-1:0];
  localparam logic [15:0]   C_CNT_MAX = 16'hFFFF;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [6:0]       r_mem [DEPTH];
  logic [SIG_W-1:0] r_sig;
  logic [15:0]      r_cnt;
  logic             r_ovf;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic [SIG_W-1:0] w_sig_next;

  // Occupancy flags and handshake qualifiers, all from registered pointers.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
              (r_wr_ptr[AW] != r_rd_ptr[AW]);
    w_pop   = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    w_push  = en && (!w_full || w_pop);
  end

  // Next MISR value: shift left, fold back the polynomial on carry-out, xor sample in.
  always_comb begin
    w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
               ^ (r_sig[SIG_W-1] ? C_POLY : '0)
               ^ {{(SIG_W-7){1'b0}}, din};
  end

  // Sample storage is not reset; only the pointers define valid contents.
  always_ff @(posedge CK) begin
    if (RN && !clr && w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointers, signature, count and sticky overflow; clr mirrors reset and
  // swallows any concurrent sample or pop.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sig    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sig    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      if (en) begin
        r_sig <= w_sig_next;
        if (r_cnt != C_CNT_MAX) begin
          r_cnt <= r_cnt + 16'd1;
        end
        // Strobe arrived but no slot was available: remember the drop.
        if (!w_push) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // Output mapping; head of FIFO is read straight from storage.
  always_comb begin
    out_valid = !w_empty;
    empty     = w_empty;
    full      = w_full;
    out_data  = r_mem[r_rd_ptr[AW-1:0]];
    sig       = r_sig;
    cnt       = r_cnt;
    ovf       = r_ovf;
  end

endmodule
`default_nettype wire

// File: tb/tb_s386_resp_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_s386_resp_capture
// Description : Directed self-checking bench for s386_resp_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s386_resp_capture;

  logic        CK;
  logic        RN;
  logic        clr;
  logic        en;
  logic [6:0]  din;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_data;
  logic        full;
  logic        empty;
  logic [15:0] sig;
  logic [15:0] cnt;
  logic        ovf;

  int n_vec;
  int n_err;

  s386_resp_capture dut (
    .CK        (CK),
    .RN        (RN),
    .clr       (clr),
    .en        (en),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .sig       (sig),
    .cnt       (cnt),
    .ovf       (ovf)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Inputs change just after a falling edge; outputs are checked at the next falling edge.
  task automatic tick();
    @(posedge CK);
    @(negedge CK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RN = 1'b0; clr = 1'b0; en = 1'b0; din = 7'h00; out_ready = 1'b0;
    @(negedge CK);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sig",   32'(sig), 32'd0);
    chk("rst_cnt",   32'(cnt), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    RN = 1'b1;
    tick();

    // Basic capture and pop
    en = 1'b1; din = 7'h01; tick();
    chk("basic_sig1", 32'(sig), 32'h0001);
    din = 7'h00; tick();
    chk("basic_sig2",  32'(sig), 32'h0002);
    chk("basic_cnt",   32'(cnt), 32'd2);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_head",  32'(out_data), 32'h01);
    en = 1'b0; out_ready = 1'b1; tick();
    chk("basic_pop_head", 32'(out_data), 32'h00);
    tick();
    chk("basic_drained", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Asynchronous reset with three entries held
    en = 1'b1; din = 7'h11; tick();
    din = 7'h12; tick();
    din = 7'h13; tick();
    en = 1'b0;
    chk("pre_rst_cnt", 32'(cnt), 32'd5);
    #1 RN = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full",  32'(full), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sig",   32'(sig), 32'd0);
    chk("arst_cnt",   32'(cnt), 32'd0);
    chk("arst_ovf",   32'(ovf), 32'd0);
    #1 RN = 1'b1;
    tick();

    // MISR feedback: walk a single one to the MSB, then fold in the polynomial
    out_ready = 1'b1;
    en = 1'b1; din = 7'h01; tick();
    din = 7'h00;
    for (int i = 0; i < 15; i++) tick();
    chk("misr_msb", 32'(sig), 32'h8000);
    tick();
    chk("misr_fold", 32'(sig), 32'h100B);
    chk("misr_cnt",  32'(cnt), 32'd17);
    chk("misr_ovf",  32'(ovf), 32'd0);
    en = 1'b0; out_ready = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr1_cnt", 32'(cnt), 32'd0);

    // Overflow: fill, then one more strobe gets dropped
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 7'(8'h10 + i);
      tick();
    end
    chk("ovf_full",   32'(full), 32'd1);
    chk("ovf_before", 32'(ovf), 32'd0);
    din = 7'h7F; tick();
    chk("ovf_set",   32'(ovf), 32'd1);
    chk("ovf_cnt",   32'(cnt), 32'd9);
    chk("ovf_full2", 32'(full), 32'd1);
    en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", 32'(out_data), 32'h10 + 32'(i));
      tick();
    end
    chk("ovf_empty",  32'(empty), 32'd1);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    out_ready = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr2_ovf", 32'(ovf), 32'd0);

    // Full with simultaneous push and pop
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 7'(8'h20 + i);
      tick();
    end
    chk("pp_full_pre", 32'(full), 32'd1);
    din = 7'h55; out_ready = 1'b1; tick();
    chk("pp_full", 32'(full), 32'd1);
    chk("pp_ovf",  32'(ovf), 32'd0);
    chk("pp_head", 32'(out_data), 32'h21);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("pp_drain", 32'(out_data), 32'h21 + 32'(i));
      tick();
    end
    chk("pp_last", 32'(out_data), 32'h55);
    tick();
    chk("pp_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // clr wins over a concurrent sample
    en = 1'b1; din = 7'h33; tick();
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    clr = 1'b1; din = 7'h2A; tick();
    clr = 1'b0; en = 1'b0;
    chk("clr_sig",   32'(sig), 32'd0);
    chk("clr_cnt",   32'(cnt), 32'd0);
    chk("clr_ovf",   32'(ovf), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    tick();
    chk("clr_absent", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
